// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : Bundles the MEM-stage request, external debug/DMA port and
//               memory-side req/ack bus of the data-memory arbiter.
//               The "master" modport is the arbiter's view: it masters the
//               memory bus and serves both requesters. The "slave" modport is
//               the surrounding environment (pipeline, external agent, memory).
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // MEM-stage requester
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          stall_m;
    // external requester
    logic          ext_req;
    logic          ext_we;
    logic [AW-1:0] ext_addr;
    logic [DW-1:0] ext_wdata;
    logic [DW-1:0] ext_rdata;
    logic          ext_ack;
    // memory side
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    // status
    logic          err;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, stall_m,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_rdata, ext_ack,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack,
        output err
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, stall_m,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_rdata, ext_ack,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack,
        input  err
    );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares a single-port data memory between the pipeline MEM
//               stage and an external debug/DMA port over a variable-latency
//               req/ack memory bus. CPU has fixed priority; a starvation
//               counter forces the external port after STARVE_LIMIT
//               contended CPU grants.
//               Optional macro DMEM_TIMEOUT_EN: abandon an access after
//               TIMEOUT_CYCLES without mem_ack, return 32'hDEAD_BEEF and
//               pulse err.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  wire logic           clk,
    input  wire logic           reset,
    dmem_arbiter_if.master      bus
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_CPU_BUSY = 2'd1,
        S_EXT_BUSY = 2'd2
    } state_t;

    localparam logic [3:0]    c_STARVE_LIM = 4'(STARVE_LIMIT);
    localparam logic [DW-1:0] c_TMO_DATA   = DW'(32'hDEAD_BEEF);

    state_t        r_state, w_state_nxt;
    logic          r_mem_req, w_mem_req_nxt;
    logic          r_mem_we, w_mem_we_nxt;
    logic [AW-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DW-1:0] r_mem_wdata, w_mem_wdata_nxt;
    logic [DW-1:0] r_cpu_rdata, w_cpu_rdata_nxt;
    logic [DW-1:0] r_ext_rdata, w_ext_rdata_nxt;
    logic          r_cpu_done, w_cpu_done_nxt;
    logic          r_ext_done, w_ext_done_nxt;
    logic [3:0]    r_starve_cnt, w_starve_nxt;

    logic          w_cpu_elig;
    logic          w_ext_elig;
    logic          w_fin;       // access ends this cycle
    logic          w_fin_load;  // owner's rdata register is updated
    logic [DW-1:0] w_fin_data;

`ifdef DMEM_TIMEOUT_EN
    localparam int            c_TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT_CYCLES - 1);
    logic [c_TMO_W-1:0] r_tmo_cnt, w_tmo_nxt;
    logic               r_err, w_err_nxt;
`endif

    // A request that completed last cycle is still asserted in its done
    // cycle; masking it here prevents granting it a second time.
    assign w_cpu_elig = bus.cpu_req & ~r_cpu_done;
    assign w_ext_elig = bus.ext_req & ~r_ext_done;

    // Next-state, grant selection and completion handling
    always_comb begin
        w_state_nxt     = r_state;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_cpu_rdata_nxt = r_cpu_rdata;
        w_ext_rdata_nxt = r_ext_rdata;
        w_cpu_done_nxt  = 1'b0;
        w_ext_done_nxt  = 1'b0;
        w_starve_nxt    = r_starve_cnt;
        w_fin           = 1'b0;
        w_fin_load      = ~r_mem_we;
        w_fin_data      = bus.mem_rdata;
`ifdef DMEM_TIMEOUT_EN
        w_tmo_nxt       = '0;
        w_err_nxt       = 1'b0;
`endif

        case (r_state)
            S_IDLE: begin
                if (w_ext_elig && (r_starve_cnt == c_STARVE_LIM)) begin
                    w_state_nxt     = S_EXT_BUSY;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = bus.ext_we;
                    w_mem_addr_nxt  = bus.ext_addr;
                    w_mem_wdata_nxt = bus.ext_wdata;
                    w_starve_nxt    = 4'd0;
                end else if (w_cpu_elig) begin
                    w_state_nxt     = S_CPU_BUSY;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = bus.cpu_we;
                    w_mem_addr_nxt  = bus.cpu_addr;
                    w_mem_wdata_nxt = bus.cpu_wdata;
                    if (!w_ext_elig) begin
                        w_starve_nxt = 4'd0;
                    end else if (r_starve_cnt != c_STARVE_LIM) begin
                        w_starve_nxt = r_starve_cnt + 4'd1;
                    end
                end else if (w_ext_elig) begin
                    w_state_nxt     = S_EXT_BUSY;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = bus.ext_we;
                    w_mem_addr_nxt  = bus.ext_addr;
                    w_mem_wdata_nxt = bus.ext_wdata;
                    w_starve_nxt    = 4'd0;
                end
            end
            S_CPU_BUSY, S_EXT_BUSY: begin
                if (bus.mem_ack) begin
                    w_fin = 1'b1;
`ifdef DMEM_TIMEOUT_EN
                end else if (r_tmo_cnt == c_TMO_LAST) begin
                    // mem_ack in this same cycle would have won above
                    w_fin      = 1'b1;
                    w_fin_load = 1'b1;
                    w_fin_data = c_TMO_DATA;
                    w_err_nxt  = 1'b1;
                end else begin
                    w_tmo_nxt = r_tmo_cnt + 1'b1;
`endif
                end
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase

        if (w_fin) begin
            w_state_nxt   = S_IDLE;
            w_mem_req_nxt = 1'b0;
            if (r_state == S_CPU_BUSY) begin
                w_cpu_done_nxt = 1'b1;
                if (w_fin_load) begin
                    w_cpu_rdata_nxt = w_fin_data;
                end
            end else begin
                w_ext_done_nxt = 1'b1;
                if (w_fin_load) begin
                    w_ext_rdata_nxt = w_fin_data;
                end
            end
        end
    end

    // State and datapath registers; reset abandons any access in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_cpu_rdata  <= '0;
            r_ext_rdata  <= '0;
            r_cpu_done   <= 1'b0;
            r_ext_done   <= 1'b0;
            r_starve_cnt <= 4'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_mem_req    <= w_mem_req_nxt;
            r_mem_we     <= w_mem_we_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_cpu_rdata  <= w_cpu_rdata_nxt;
            r_ext_rdata  <= w_ext_rdata_nxt;
            r_cpu_done   <= w_cpu_done_nxt;
            r_ext_done   <= w_ext_done_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

`ifdef DMEM_TIMEOUT_EN
    // Wait-for-ack counter and one-cycle timeout pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            r_tmo_cnt <= w_tmo_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign bus.err = r_err;
`else
    // No timeout logic: the comparison is constant-false for any legal
    // TIMEOUT_CYCLES, so err is tied low.
    assign bus.err = (TIMEOUT_CYCLES < 0);
`endif

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.cpu_rdata = r_cpu_rdata;
    assign bus.ext_rdata = r_ext_rdata;
    assign bus.ext_ack   = r_ext_done;
    // Covers both waiting for grant and in flight; falls in the done cycle
    assign bus.stall_m   = bus.cpu_req & ~r_cpu_done;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter with a small
//               behavioural memory (programmable ack latency, 0 = never).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

    dmem_arbiter #(
        .AW(32), .DW(32), .STARVE_LIMIT(4), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // ---------------- memory model ----------------
    logic [31:0] mem [0:255];
    int          mem_lat   = 2;
    int          busy_cnt  = 0;
    int          req_cycles = 0;
    int          stab_err  = 0;
    logic        prev_req  = 1'b0;
    logic [31:0] lat_addr, lat_wdata;
    logic [31:0] grant_q[$];

    // Responds at the falling edge; logs each new mem_req with its address
    always @(negedge clk) begin
        if (reset) begin
            bus.mem_ack = 1'b0;
            busy_cnt    = 0;
            prev_req    = 1'b0;
        end else begin
            if (bus.mem_req && !prev_req) begin
                grant_q.push_back(bus.mem_addr);
                lat_addr   = bus.mem_addr;
                lat_wdata  = bus.mem_wdata;
                req_cycles = 0;
            end
            if (bus.mem_req) begin
                req_cycles++;
                if (bus.mem_addr !== lat_addr || bus.mem_wdata !== lat_wdata)
                    stab_err++;
            end
            if (bus.mem_req && !bus.mem_ack) begin
                busy_cnt++;
                if (mem_lat != 0 && busy_cnt == mem_lat) begin
                    bus.mem_ack = 1'b1;
                    if (bus.mem_we) begin
                        mem[bus.mem_addr[9:2]] = bus.mem_wdata;
                        bus.mem_rdata = 32'hBAD0_0000;
                    end else begin
                        bus.mem_rdata = mem[bus.mem_addr[9:2]];
                    end
                end
            end else begin
                bus.mem_ack = 1'b0;
                busy_cnt    = 0;
            end
            prev_req = bus.mem_req;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns in the done cycle (stall_m low)
    task automatic cpu_op(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          output int stalls);
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = wd;
        #1;
        stalls = 0;
        while (bus.stall_m && stalls < 200) begin
            stalls++;
            @(negedge clk); #1;
        end
    endtask

    // Called at a falling edge; returns in the ext_ack cycle with ext_req dropped
    task automatic ext_op(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          output int waits);
        bus.ext_req = 1'b1; bus.ext_we = we; bus.ext_addr = a; bus.ext_wdata = wd;
        #1;
        waits = 0;
        while (!bus.ext_ack && waits < 200) begin
            waits++;
            @(negedge clk); #1;
        end
        bus.ext_req = 1'b0;
    endtask

    int          stalls, waits, cpu_done_cyc, ack_cyc, ack_cnt, cpu_done_n, k;
    int          rise, err_cnt, err_cyc, rel;
    logic        ext_served, snap_taken;
    logic [31:0] rd, ext_rd, snap;

    initial begin
        reset = 1'b1;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ext_req = 1'b0; bus.ext_we = 1'b0; bus.ext_addr = '0; bus.ext_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'h1234_5678;   // 0x40
        mem[8'h11] = 32'h1111_2222;   // 0x44
        mem[8'h41] = 32'h3333_4444;   // 0x104

        // ---- reset state ----
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_req",   {31'b0, bus.mem_req}, 32'd0);
        chk("rst_stall_m",   {31'b0, bus.stall_m}, 32'd0);
        chk("rst_ext_ack",   {31'b0, bus.ext_ack}, 32'd0);
        chk("rst_err",       {31'b0, bus.err},     32'd0);
        chk("rst_cpu_rdata", bus.cpu_rdata,        32'd0);
        chk("rst_mem_addr",  bus.mem_addr,         32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // ---- single CPU load, ack on 2nd mem_req cycle ----
        grant_q.delete();
        cpu_op(1'b0, 32'h40, 32'h0, stalls);
        chk("t1_stall_cycles", 32'(stalls), 32'd3);
        chk("t1_cpu_rdata",    bus.cpu_rdata, 32'h1234_5678);
        chk("t1_mem_req_cyc",  32'(req_cycles), 32'd2);
        chk("t1_grants",       32'(grant_q.size()), 32'd1);
        bus.cpu_req = 1'b0;
        @(negedge clk);

        // ---- simultaneous CPU and ext requests ----
        grant_q.delete();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h44;
        bus.ext_req = 1'b1; bus.ext_we = 1'b0; bus.ext_addr = 32'h104;
        cpu_done_cyc = -1; ack_cyc = -1; ack_cnt = 0; rd = '0; ext_rd = '0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (bus.cpu_req && !bus.stall_m) begin
                cpu_done_cyc = c; rd = bus.cpu_rdata; bus.cpu_req = 1'b0;
            end
            if (bus.ext_ack) begin
                ack_cnt++; ack_cyc = c; ext_rd = bus.ext_rdata; bus.ext_req = 1'b0;
            end
            @(negedge clk);
        end
        chk("t2_cpu_done_cyc", 32'(cpu_done_cyc), 32'd3);
        chk("t2_ext_ack_cyc",  32'(ack_cyc),      32'd6);
        chk("t2_ext_ack_cnt",  32'(ack_cnt),      32'd1);
        chk("t2_first_grant",  grant_q[0],        32'h44);
        chk("t2_second_grant", grant_q[1],        32'h104);
        chk("t2_cpu_rdata",    rd,                32'h1111_2222);
        chk("t2_ext_rdata",    ext_rd,            32'h3333_4444);

        // ---- starvation guard: continuous CPU stores vs. waiting ext ----
        // The external agent only presents its request outside CPU done
        // cycles, so every CPU grant below is a contended one.
        grant_q.delete();
        ext_served = 1'b0; snap_taken = 1'b0; snap = '1; cpu_done_n = 0; k = 0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
        bus.cpu_addr = 32'h80; bus.cpu_wdata = 32'hC000_0000;
        bus.ext_req = 1'b1; bus.ext_we = 1'b1;
        bus.ext_addr = 32'h108; bus.ext_wdata = 32'h5555_0000;
        for (int c = 0; c < 80 && cpu_done_n < 5; c++) begin
            #1;
            if (grant_q.size() == 4 && !snap_taken) begin
                snap = 32'(dut.r_starve_cnt); snap_taken = 1'b1;
            end
            if (bus.ext_ack) ext_served = 1'b1;
            if (!bus.stall_m) begin
                cpu_done_n++; k++;
                bus.cpu_addr  = 32'h80 + 32'(4 * k);
                bus.cpu_wdata = 32'hC000_0000 + 32'(k);
            end
            bus.ext_req = !ext_served && bus.stall_m;
            @(negedge clk);
        end
        bus.cpu_req = 1'b0; bus.ext_req = 1'b0;
        chk("t3_grants",     32'(grant_q.size()), 32'd6);
        chk("t3_cpu_g1",     grant_q[0], 32'h80);
        chk("t3_cpu_g4",     grant_q[3], 32'h8C);
        chk("t3_ext_g5",     grant_q[4], 32'h108);
        chk("t3_cpu_g6",     grant_q[5], 32'h90);
        chk("t3_starve_sat", snap, 32'd4);
        @(negedge clk); #1;
        chk("t3_starve_clr", 32'(dut.r_starve_cnt), 32'd0);
        chk("t3_ext_wr_mem", mem[8'h42], 32'h5555_0000);
        chk("t3_cpu_rd_hold", bus.cpu_rdata, 32'h1111_2222);

        // ---- ext write then CPU load of the same word ----
        @(negedge clk);
        mem_lat = 3; grant_q.delete(); stab_err = 0;
        ext_op(1'b1, 32'h100, 32'hA5A5_A5A5, waits);
        chk("t4_ext_wait",    32'(waits), 32'd4);
        chk("t4_ext_rd_hold", bus.ext_rdata, 32'h3333_4444);
        @(negedge clk);
        cpu_op(1'b0, 32'h100, 32'h0, stalls);
        chk("t4_stall_cycles", 32'(stalls), 32'd4);
        chk("t4_cpu_rdata",    bus.cpu_rdata, 32'hA5A5_A5A5);
        chk("t4_mem_stable",   32'(stab_err), 32'd0);
        bus.cpu_req = 1'b0;
        @(negedge clk);

        // ---- reset during CPU_BUSY ----
        mem_lat = 0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h40;
        @(negedge clk); #1;
        chk("t5_busy_req", {31'b0, bus.mem_req}, 32'd1);
        reset = 1'b1; bus.cpu_req = 1'b0;
        #1;
        chk("t5_rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
        chk("t5_rst_stall",   {31'b0, bus.stall_m}, 32'd0);
        chk("t5_rst_ext_ack", {31'b0, bus.ext_ack}, 32'd0);
        chk("t5_rst_err",     {31'b0, bus.err},     32'd0);
        chk("t5_rst_rdata",   bus.cpu_rdata,        32'd0);
        @(negedge clk);
        reset = 1'b0; mem_lat = 2;
        @(negedge clk);
        cpu_op(1'b0, 32'h40, 32'h0, stalls);
        chk("t5_post_stalls", 32'(stalls), 32'd3);
        chk("t5_post_rdata",  bus.cpu_rdata, 32'h1234_5678);
        bus.cpu_req = 1'b0;
        @(negedge clk);

        // ---- memory never acks ----
        mem_lat = 0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h48;
        rise = -1; err_cnt = 0; err_cyc = -1; rel = -1; rd = '0;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (bus.mem_req && rise < 0) rise = c;
            if (bus.err) begin err_cnt++; err_cyc = c; end
            if (bus.cpu_req && !bus.stall_m && rel < 0) begin
                rel = c; rd = bus.cpu_rdata; bus.cpu_req = 1'b0;
            end
            @(negedge clk);
        end
`ifdef DMEM_TIMEOUT_EN
        chk("t6_err_delay", 32'(err_cyc - rise), 32'd64);
        chk("t6_err_pulses", 32'(err_cnt), 32'd1);
        chk("t6_release_cyc", 32'(rel), 32'(err_cyc));
        chk("t6_cpu_rdata", rd, 32'hDEAD_BEEF);
`else
        chk("t6_rise_cyc", 32'(rise), 32'd1);
        chk("t6_no_release", 32'(rel), 32'hFFFF_FFFF);
        chk("t6_no_err", 32'(err_cnt), 32'd0);
        #1;
        chk("t6_stall_held", {31'b0, bus.stall_m}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
